// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared encodings for the 1-to-4 demux dispatch controller.
package demux_dispatch_ctrl_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  typedef enum logic {ST_IDLE, ST_FULL} state_t;
endpackage

// File: rtl/demux_dispatch_ctrl_rr_pick4.sv
// Round-robin picker: first enabled channel at or after ptr, modulo NUM_CH.
module rr_pick4
  import demux_dispatch_ctrl_pkg::*;
(
  input  logic [SEL_W-1:0]  ptr,
  input  logic [NUM_CH-1:0] en,
  output logic [SEL_W-1:0]  ch,
  output logic              any_en
);
  logic [SEL_W-1:0] idx;

  always_comb begin
    ch     = ptr;
    any_en = |en;
    idx    = '0;
    // Walk from the farthest offset inward so the nearest enabled channel wins.
    for (int k = NUM_CH-1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (en[idx]) ch = idx;
    end
  end
endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Valid/ready dispatcher: steers each input item to one of four channels
// through a one-deep output register, addressed or round-robin.
module demux_dispatch_ctrl
  import demux_dispatch_ctrl_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SEL_W-1:0]  in_dest,
  output logic [DW-1:0]     out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic              busy,
  output logic [CW-1:0]     drop_cnt
);
  state_t           state, state_nxt;
  logic [SEL_W-1:0] rr_ptr, rr_ch, ch;
  logic             any_en, out_fire, in_fire, drop, load;

  rr_pick4 u_pick (
    .ptr    (rr_ptr),
    .en     (chan_en),
    .ch     (rr_ch),
    .any_en (any_en)
  );

  assign busy     = (state == ST_FULL);
  assign out_fire = busy & out_ready[out_sel];
  assign in_ready = ((state == ST_IDLE) | out_fire) & ((mode == MODE_ADDR) | any_en);
  assign in_fire  = in_valid & in_ready;
  assign ch       = (mode == MODE_RR) ? rr_ch : in_dest;
  // Addressed items aimed at a disabled channel are consumed and counted.
  assign drop     = in_fire & (mode == MODE_ADDR) & ~chan_en[in_dest];
  assign load     = in_fire & ~drop;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (load) state_nxt = ST_FULL;
      ST_FULL: if (out_fire) state_nxt = load ? ST_FULL : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= '0;
      drop_cnt  <= '0;
      rr_ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        out_data  <= in_data;
        out_sel   <= ch;
        out_valid <= NUM_CH'(1) << ch;
      end else if (out_fire) begin
        out_valid <= '0;
      end
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CW'(1);
      if (in_fire && mode == MODE_RR) rr_ptr <= rr_ch + SEL_W'(1);
    end
  end
endmodule
